// File: rtl/spi_cmd_slave_if.sv
// spi_cmd_slave_if: SPI pins plus the byte-side handshake of the command front end
interface spi_cmd_slave_if;
    logic       SCLK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] tx_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_load;
    logic       frame_err;
    logic       busy;
    modport slave (
        input  SCLK, SS, MOSI, tx_data,
        output MISO, rx_byte, rx_valid, tx_load, frame_err, busy
    );
    modport master (
        output SCLK, SS, MOSI, tx_data,
        input  MISO, rx_byte, rx_valid, tx_load, frame_err, busy
    );
endinterface

// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: mode-0 SPI slave, deserialises command bytes and returns a status byte
module spi_cmd_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_BYTE  = 8'd0,
    parameter logic       IDLE_MISO   = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    spi_cmd_slave_if.slave spi
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sy, ss_sy, mosi_sy;
    logic                   sclk_h, ss_h, mosi_h;
    logic [SYNC_STAGES:0]   flushed;
    logic                   armed;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [2:0]             bit_cnt, cnt_nxt;
    logic [6:0]             rx_sr, tx_sr;
    logic                   reload;

    assign cnt_nxt = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;

    // Synchronisers, history flops and registered edge pulses. SS falls are only
    // trusted once the pipeline holds real pin samples and SS has been seen high,
    // so a reset released with SS already low cannot start a frame.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk_sy   <= '0;
            ss_sy     <= '1;
            mosi_sy   <= '0;
            sclk_h    <= 1'b0;
            ss_h      <= 1'b1;
            mosi_h    <= 1'b0;
            flushed   <= '0;
            armed     <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
        end else begin
            sclk_sy   <= {sclk_sy[SYNC_STAGES-2:0], spi.SCLK};
            ss_sy     <= {ss_sy[SYNC_STAGES-2:0], spi.SS};
            mosi_sy   <= {mosi_sy[SYNC_STAGES-2:0], spi.MOSI};
            sclk_h    <= sclk_sy[SYNC_STAGES-1];
            ss_h      <= ss_sy[SYNC_STAGES-1];
            mosi_h    <= mosi_sy[SYNC_STAGES-1];
            flushed   <= {flushed[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (flushed[SYNC_STAGES] & ss_h);
            sclk_rise <= sclk_sy[SYNC_STAGES-1] & ~sclk_h;
            sclk_fall <= ~sclk_sy[SYNC_STAGES-1] & sclk_h;
            ss_fall   <= armed & ~ss_sy[SYNC_STAGES-1] & ss_h;
            ss_rise   <= ss_sy[SYNC_STAGES-1] & ~ss_h;
        end

    // Frame FSM: the SCLK edge of a cycle is applied before an SS rise in the same cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            spi.rx_byte   <= RESET_BYTE;
            spi.rx_valid  <= 1'b0;
            spi.tx_load   <= 1'b0;
            spi.frame_err <= 1'b0;
            spi.busy      <= 1'b0;
            spi.MISO      <= IDLE_MISO;
            bit_cnt       <= 3'd0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            reload        <= 1'b0;
        end else begin
            spi.rx_valid  <= 1'b0;
            spi.tx_load   <= 1'b0;
            spi.frame_err <= 1'b0;
            case (state)
                IDLE: if (ss_fall) begin
                    state       <= LOAD;
                    spi.busy    <= 1'b1;
                    spi.tx_load <= 1'b1;
                    spi.MISO    <= spi.tx_data[7];
                    tx_sr       <= spi.tx_data[6:0];
                    bit_cnt     <= 3'd0;
                    reload      <= 1'b0;
                end
                LOAD: if (ss_rise) begin
                    state    <= IDLE;
                    spi.busy <= 1'b0;
                    spi.MISO <= IDLE_MISO;
                end else
                    state <= SHIFT;
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr   <= {rx_sr[5:0], mosi_h};
                        bit_cnt <= cnt_nxt;
                        if (bit_cnt == 3'd7) begin
                            spi.rx_byte  <= {rx_sr, mosi_h};
                            spi.rx_valid <= 1'b1;
                            reload       <= 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (reload) begin
                            tx_sr       <= spi.tx_data[6:0];
                            spi.MISO    <= spi.tx_data[7];
                            spi.tx_load <= 1'b1;
                            reload      <= 1'b0;
                        end else begin
                            tx_sr    <= {tx_sr[5:0], 1'b0};
                            spi.MISO <= tx_sr[6];
                        end
                    end
                    if (ss_rise) begin
                        state         <= IDLE;
                        spi.busy      <= 1'b0;
                        spi.MISO      <= IDLE_MISO;
                        spi.frame_err <= cnt_nxt != 3'd0;
                        bit_cnt       <= 3'd0;
                        rx_sr         <= '0;
                        reload        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi_cmd_slave.sv
// tb_spi_cmd_slave: drives SPI frames as a mode-0 master and checks against a byte-level model
module tb_spi_cmd_slave;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_cmd_slave_if spi();
    spi_cmd_slave #(.SYNC_STAGES(3)) dut (.clk(clk), .rst_n(rst_n), .spi(spi.slave));

    int         n_cmp = 0, n_bad = 0;
    int         n_valid = 0, n_load = 0, n_ferr = 0;
    int         edge_cnt = 0, t_rise = 0, t_ssf = 0, lat_rx = 0, lat_tx = 0;
    bit         ss_meas = 1'b0;
    logic [7:0] mb [0:3];
    logic [7:0] ttx [0:3];
    logic [7:0] exp_rx [$];
    logic [7:0] tx_q [$];
    logic [7:0] last_rx = 8'h00;
    int         nb, pb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) edge_cnt++;

    // Byte-level observer: each rx_valid must deliver the next fully sent byte,
    // and it is also the moment the master side presents the next status byte.
    always @(negedge clk) begin
        if (spi.rx_valid) begin
            n_valid++;
            lat_rx = edge_cnt - t_rise;
            if (exp_rx.size() != 0) check("rx_byte", spi.rx_byte, exp_rx.pop_front());
            else check("rx_valid_spurious", exp_rx.size(), 1);
            if (tx_q.size() != 0) spi.tx_data = tx_q.pop_front();
        end
        if (spi.tx_load) begin
            n_load++;
            if (ss_meas) begin
                lat_tx  = edge_cnt - t_ssf;
                ss_meas = 1'b0;
            end
        end
        if (spi.frame_err) n_ferr++;
    end

    // One SS-low frame: nfull whole bytes mb[0..], then pbits bits of mb[nfull];
    // align raises SS together with the last SCLK rising edge.
    task automatic do_frame(input int nfull, input int pbits, input bit align);
        int         v0, l0, f0;
        logic [7:0] mi;
        v0 = n_valid;
        l0 = n_load;
        f0 = n_ferr;
        spi.tx_data = ttx[0];
        for (int j = 1; j < nfull; j++) tx_q.push_back(ttx[j]);
        for (int j = 0; j < nfull; j++) exp_rx.push_back(mb[j]);
        t_ssf   = edge_cnt;
        ss_meas = 1'b1;
        spi.SS  = 1'b0;
        repeat (12) @(negedge clk);
        for (int j = 0; j < nfull + (pbits != 0 ? 1 : 0); j++) begin
            mi = 8'h00;
            for (int i = 0; i < (j < nfull ? 8 : pbits); i++) begin
                spi.MOSI = mb[j][7-i];
                repeat (H) @(negedge clk);
                spi.SCLK = 1'b1;
                if (align && j == nfull - 1 && i == 7) spi.SS = 1'b1;
                if (i == 7) t_rise = edge_cnt;
                mi = {mi[6:0], spi.MISO};
                repeat (H) @(negedge clk);
                spi.SCLK = 1'b0;
            end
            if (j < nfull) check("miso_byte", mi, ttx[j]);
        end
        repeat (H) @(negedge clk);
        spi.SS = 1'b1;
        if (nfull != 0) last_rx = mb[nfull-1];
        repeat (20) @(negedge clk);
        check("rx_valid_count", n_valid - v0, nfull);
        check("tx_load_count", n_load - l0, nfull + 1 - (align ? 1 : 0));
        check("frame_err_count", n_ferr - f0, pbits != 0 ? 1 : 0);
        check("rx_byte_held", spi.rx_byte, last_rx);
        check("busy_idle", spi.busy, 0);
        check("miso_idle", spi.MISO, 0);
        check("rx_pending", exp_rx.size(), 0);
        tx_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        spi.SS      = 1'b0;
        spi.SCLK    = 1'b0;
        spi.MOSI    = 1'b0;
        spi.tx_data = 8'h5A;
        for (int k = 0; k < 6; k++) begin
            repeat (2) @(negedge clk);
            spi.SCLK = ~spi.SCLK;
            spi.MOSI = 1'b1;
        end
        check("reset_rx_byte", spi.rx_byte, 8'h00);
        check("reset_miso", spi.MISO, 0);
        check("reset_busy", spi.busy, 0);
        check("reset_pulses", {spi.rx_valid, spi.tx_load, spi.frame_err}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            spi.MOSI = 1'($urandom);
            repeat (H) @(negedge clk);
            spi.SCLK = ~spi.SCLK;
        end
        repeat (10) @(negedge clk);
        check("post_reset_no_valid", n_valid, 0);
        check("post_reset_no_load", n_load, 0);
        check("post_reset_busy", spi.busy, 0);
        spi.SS = 1'b1;
        repeat (20) @(negedge clk);

        mb[0] = 8'h01; ttx[0] = 8'd21;
        do_frame(1, 0, 1'b0);
        check("rx_latency", lat_rx, 5);
        check("tx_load_latency", lat_tx, 5);

        mb[0] = 8'h02; mb[1] = 8'h25; mb[2] = 8'h1D;
        ttx[0] = 8'd20; ttx[1] = 8'd36; ttx[2] = 8'd20;
        do_frame(3, 0, 1'b0);

        mb[0] = 8'hAA; ttx[0] = 8'h77;
        do_frame(0, 5, 1'b0);

        mb[0] = 8'h40; ttx[0] = 8'hC3;
        do_frame(1, 0, 1'b0);

        mb[0] = 8'h99; ttx[0] = 8'h3C;
        do_frame(1, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            nb = $urandom_range(1, 3);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int j = 0; j < 4; j++) begin
                mb[j]  = 8'($urandom);
                ttx[j] = 8'($urandom);
            end
            do_frame(nb, pb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_cmd_slave.md
Name: spi_cmd_slave

Overview:
- SPI slave front end between the MBED SPI master and the command interpreter.
- Synchronises SCLK/SS/MOSI into the clk domain and deserialises MOSI into 8-bit command bytes.
- Presents each byte as a held register plus a one-cycle valid strobe.
- Serialises a status byte from the interpreter back on MISO.
- Mode 0 (CPOL=0, CPHA=0), MSB first, single slave.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each of SCLK, SS, MOSI; legal values 2..3.
- RESET_BYTE, 8'd0, value of rx_byte after reset.
- IDLE_MISO, 1'b0, level driven on MISO while SS is high.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock from master, asynchronous; maximum frequency clk/8.
- SS  input  1  SPI slave select, active low, asynchronous.
- MOSI  input  1  SPI data from master, asynchronous.
- tx_data  input  8  byte to return to master; sampled at each byte start.
- MISO  output  1  SPI data to master.
- rx_byte  output  8  last complete received byte; held until the next complete byte.
- rx_valid  output  1  one-cycle pulse when rx_byte updates.
- tx_load  output  1  one-cycle pulse when tx_data is captured.
- frame_err  output  1  one-cycle pulse when SS deasserts mid-byte.
- busy  output  1  high while synchronised SS is low.

Behaviour:
- Reset and interface:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - On rst_n low: all synchroniser flops go to idle (SCLK=0, SS=1, MOSI=0).
  - Also on reset: rx_byte=RESET_BYTE, rx_valid=0, tx_load=0, frame_err=0, busy=0, MISO=IDLE_MISO, bit_cnt=0, shift registers=0, state=IDLE.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops, followed by one history flop for edge detection.
  - sclk_rise/sclk_fall/ss_fall/ss_rise are single-cycle pulses derived from the synchronised values only.
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - busy=0 and MISO=IDLE_MISO.
  - On ss_fall go to LOAD.
- LOAD (exactly one cycle):
  - tx_sr<=tx_data, tx_load=1, bit_cnt<=0.
  - MISO<=tx_data[7], valid before the first SCLK rising edge.
  - Go to SHIFT.
- SHIFT:
  - On sclk_rise: rx_sr<={rx_sr[6:0], MOSI_sync}, bit_cnt<=bit_cnt+1.
  - On sclk_rise when bit_cnt==7:
    - rx_byte<={rx_sr[6:0], MOSI_sync}, rx_valid=1 next cycle, bit_cnt<=0.
    - Set reload flag.
  - On sclk_fall with reload flag clear: tx_sr<={tx_sr[6:0],1'b0}, MISO<=tx_sr[6].
  - On sclk_fall with reload flag set:
    - tx_sr<=tx_data, MISO<=tx_data[7], tx_load=1, clear reload flag.
    - This gives multi-byte frames with a fresh status byte per byte.
  - On ss_rise with bit_cnt==0: return to IDLE silently.
  - On ss_rise with bit_cnt!=0: frame_err=1 for one cycle, discard partial rx_sr, rx_byte unchanged, return to IDLE.
- Simultaneous events:
  - ss_rise in the same cycle as sclk_rise: the SCLK edge is processed first. If it completes bit 8, rx_valid fires and no frame_err is raised.
  - sclk_rise and sclk_fall are mutually exclusive by construction.
  - ss_fall while in SHIFT is impossible; no special handling.
  - SCLK edges while in IDLE or LOAD are ignored.
- Latency:
  - rx_valid rises exactly SYNC_STAGES+2 clk edges after the first clk edge that samples the 8th SCLK rising edge high at the pin.
  - tx_load rises SYNC_STAGES+2 edges after SS low is first sampled.
- Width rules:
  - bit_cnt is 3 bits and wraps 7->0 on byte completion.
  - rx_byte and rx_valid never change on a partial byte.
- Reset mid-frame: returns to idle values immediately. The next byte is recognised only after a fresh SS falling edge.

Test Plan:
- Reset: assert rst_n=0 with SS low and SCLK toggling -> rx_byte=8'h00, MISO=0, busy=0, no pulses; after release, no rx_valid until SS goes high then low again.
- Single byte: tx_data=8'd21; master sends 8'h01 at clk/8 -> one rx_valid pulse, rx_byte=8'h01, master reads 8'h15 on MISO, tx_load pulsed once.
- Multi-byte frame: SS held low for 3 bytes 8'h02, 8'h25, 8'h1D; tx_data changes 20->36->20 between bytes -> three rx_valid pulses in order, final rx_byte=8'h1D, master reads 8'h14, 8'h24, 8'h14.
- Abort: SS rises after 5 bits of 8'hAA -> frame_err single pulse, rx_byte retains previous value 8'h1D, no rx_valid; next full byte 8'h40 received correctly.
- Boundary: SS rise in the same clk cycle as the 8th sclk_rise (forced via aligned pin edges) -> rx_valid=1, rx_byte=sent byte 8'h99, frame_err=0.
- Latency check with SYNC_STAGES=3: count clk edges from the 8th SCLK pin rising edge to rx_valid -> exactly 5.
